// File: rtl/dmem_dma.sv
// Data-memory block copier: reads one word, writes it, repeats in ascending order.
// Optional running checksum of the copied words is enabled by DMEM_DMA_CSUM_EN.
module dmem_dma #(
    parameter int D = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [A-1:0] src,
    input  logic [A-1:0] dst,
    input  logic [A:0]   len,
    output logic [A-1:0] dmem_addr,
    output logic [D-1:0] dmem_in,
    output logic         dmem_en,
    input  logic [D-1:0] dmem_out,
    output logic         busy,
`ifdef DMEM_DMA_CSUM_EN
    output logic [D-1:0] csum,
`endif
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t       state_reg, state_next;
    logic [A-1:0] src_reg, src_next;
    logic [A-1:0] dst_reg, dst_next;
    logic [A:0]   len_reg, len_next;
    logic [A:0]   idx_reg, idx_next;
    logic [D-1:0] word_reg, word_next;
    logic [A:0]   idx_inc;

    logic [A-1:0] addr_reg, addr_next;
    logic [D-1:0] in_reg, in_next;
    logic         en_reg, en_next;
    logic         busy_reg, busy_next;
    logic         done_reg, done_next;

    assign idx_inc = idx_reg + {{A{1'b0}}, 1'b1};

    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        word_next  = word_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    src_next   = src;
                    dst_next   = dst;
                    len_next   = len;
                    idx_next   = '0;
                    state_next = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                word_next  = dmem_out;
                state_next = S_WRITE;
            end
            S_WRITE: begin
                idx_next   = idx_inc;
                state_next = (idx_inc == len_reg) ? S_DONE : S_READ;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they are registered and
    // stay stable for the whole cycle they belong to.
    always_comb begin
        addr_next = '0;
        in_next   = '0;
        en_next   = 1'b0;
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            S_READ: begin
                busy_next = 1'b1;
                addr_next = src_next + idx_next[A-1:0];
            end
            S_WRITE: begin
                busy_next = 1'b1;
                en_next   = 1'b1;
                addr_next = dst_next + idx_next[A-1:0];
                in_next   = word_next;
            end
            S_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                done_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            word_reg  <= '0;
            addr_reg  <= '0;
            in_reg    <= '0;
            en_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            word_reg  <= word_next;
            addr_reg  <= addr_next;
            in_reg    <= in_next;
            en_reg    <= en_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign dmem_addr = addr_reg;
    assign dmem_in   = in_reg;
    assign dmem_en   = en_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

`ifdef DMEM_DMA_CSUM_EN
    logic [D-1:0] csum_reg;

    // word_reg holds the word being written throughout each WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_reg <= '0;
        end else if (state_reg == S_IDLE && start) begin
            csum_reg <= '0;
        end else if (state_reg == S_WRITE) begin
            csum_reg <= csum_reg + word_reg;
        end
    end

    assign csum = csum_reg;
`endif

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: a RAM model on the bus plus a word-by-word reference copy
// of memory; timing, address order and final contents are checked per copy.
module tb_dmem_dma;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] src, dst;
    logic [8:0] len;
    logic [7:0] dmem_addr, dmem_in, dmem_out;
    logic       dmem_en, busy, done;
`ifdef DMEM_DMA_CSUM_EN
    logic [7:0] csum;
`endif

    dmem_dma #(.D(8), .A(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .dmem_addr(dmem_addr), .dmem_in(dmem_in), .dmem_en(dmem_en),
        .dmem_out(dmem_out), .busy(busy),
`ifdef DMEM_DMA_CSUM_EN
        .csum(csum),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic [7:0] ref_mem [256];
    logic       tb_we;
    logic [7:0] tb_wa, tb_wd;

    always @(posedge clk) begin
        if (tb_we) ram[tb_wa] <= tb_wd;
        else if (dmem_en) ram[dmem_addr] <= dmem_in;
    end
    assign dmem_out = ram[dmem_addr];

    int tests_run = 0;
    int tests_failed = 0;

    int         done_k, busy_n, en_n, done_n;
    logic       post_busy, post_en;
    logic [7:0] csum_at_done;
    logic [7:0] model_sum;
    logic [7:0] addr_q[$];

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Reference: copy n words in strictly ascending order, modulo-256 addresses.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        model_sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            ref_mem[8'(d + 8'(i))] = ref_mem[8'(s + 8'(i))];
            model_sum = model_sum + ref_mem[8'(s + 8'(i))];
        end
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    function automatic int seq_diffs(input logic [7:0] s, input logic [7:0] d, input int n);
        int e = 0;
        if (addr_q.size() != 2 * n) return 1;
        for (int i = 0; i < n; i++) begin
            if (addr_q[2*i]   !== 8'(s + 8'(i))) e++;
            if (addr_q[2*i+1] !== 8'(d + 8'(i))) e++;
        end
        return e;
    endfunction

    // Pulses start in cycle 0, then observes cycles 1..window. Inputs are scrambled
    // after the start edge; start is re-pulsed after cycle glitch_k, rst after rst_k.
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                            input int glitch_k, input int rst_k, input int window);
        done_k = -1; busy_n = 0; en_n = 0; done_n = 0;
        post_busy = 1'b0; post_en = 1'b0; csum_at_done = 8'h00;
        addr_q.delete();
        @(negedge clk);
        start = 1'b1; src = s; dst = d; len = n;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (busy) begin busy_n++; addr_q.push_back(dmem_addr); end
            if (dmem_en) en_n++;
            if (done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
`ifdef DMEM_DMA_CSUM_EN
                    csum_at_done = csum;
`endif
                end
            end
            if (k == rst_k + 1) begin post_busy = busy; post_en = dmem_en; end
            if (k == 1) begin src = 8'($urandom); dst = 8'($urandom); len = 9'($urandom); end
            start = (k == glitch_k);
            rst   = (k == rst_k);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; src = 8'h33; dst = 8'h44; len = 9'd5;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy, done);
        end
        tests_run++;
        if (dmem_en !== 1'b0 || dmem_addr !== 8'h00 || dmem_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_bus: en=%b addr=%h in=%h, required 0 00 00", dmem_en, dmem_addr, dmem_in);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_start_ignored: busy=%b done=%b, required 0 0", busy, done);
        end
        $display("[TB] reset done");
    endtask

    task automatic test_basic();
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        model_copy(8'h10, 8'h80, 4);
        run_copy(8'h10, 8'h80, 9'd4, 0, 0, 12);
        tests_run++;
        if (done_k !== 9 || done_n !== 1) begin
            tests_failed++;
            $display("FAIL basic_done: cycle=%0d pulses=%0d, required 9 1", done_k, done_n);
        end
        tests_run++;
        if (busy_n !== 8 || en_n !== 4) begin
            tests_failed++;
            $display("FAIL basic_busy_en: busy=%0d en=%0d, required 8 4", busy_n, en_n);
        end
        tests_run++;
        if (mem_diffs() !== 0 || ram[8'h83] !== 8'h44) begin
            tests_failed++;
            $display("FAIL basic_mem: %0d words differ, ram[83]=%h required 44", mem_diffs(), ram[8'h83]);
        end
        $display("[TB] basic copy 10->80 len 4: done at %0d", done_k);
    endtask

    task automatic test_zero_len();
        model_copy(8'h05, 8'h06, 0);
        run_copy(8'h05, 8'h06, 9'd0, 0, 0, 5);
        tests_run++;
        if (done_k !== 1 || done_n !== 1) begin
            tests_failed++;
            $display("FAIL zero_done: cycle=%0d pulses=%0d, required 1 1", done_k, done_n);
        end
        tests_run++;
        if (en_n !== 0 || busy_n !== 0 || mem_diffs() !== 0) begin
            tests_failed++;
            $display("FAIL zero_nowrite: en=%0d busy=%0d diffs=%0d, required 0 0 0", en_n, busy_n, mem_diffs());
        end
        $display("[TB] zero length: done at %0d", done_k);
    endtask

    task automatic test_wrap();
        poke(8'hFE, 8'hA1); poke(8'hFF, 8'hB2); poke(8'h00, 8'hC3);
        model_copy(8'hFE, 8'h01, 3);
        run_copy(8'hFE, 8'h01, 9'd3, 0, 0, 10);
        tests_run++;
        if (seq_diffs(8'hFE, 8'h01, 3) !== 0) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d addresses (of %0d seen) wrong, required FE 01 FF 02 00 03",
                     seq_diffs(8'hFE, 8'h01, 3), addr_q.size());
        end
        tests_run++;
        if (mem_diffs() !== 0 || ram[8'h03] !== 8'hC3) begin
            tests_failed++;
            $display("FAIL wrap_mem: %0d words differ, ram[03]=%h required C3", mem_diffs(), ram[8'h03]);
        end
        $display("[TB] wrap copy FE->01 len 3: done at %0d", done_k);
    endtask

    task automatic test_overlap();
        poke(8'h20, 8'h5A); poke(8'h21, 8'h00);
        model_copy(8'h20, 8'h21, 2);
        run_copy(8'h20, 8'h21, 9'd2, 0, 0, 8);
        tests_run++;
        if (ram[8'h21] !== 8'h5A || ram[8'h22] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL overlap_mem: ram[21]=%h ram[22]=%h, required 5A 5A", ram[8'h21], ram[8'h22]);
        end
        $display("[TB] overlap copy 20->21 len 2: ram[22]=%h", ram[8'h22]);
    endtask

    task automatic test_reset_mid();
        logic [7:0] s, d;
        s = 8'($urandom); d = s + 8'h40;
        model_copy(s, d, 2);
        run_copy(s, d, 9'd8, 0, 5, 14);
        tests_run++;
        if (done_n !== 0 || post_busy !== 1'b0 || post_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: done_pulses=%0d busy=%b en=%b, required 0 0 0", done_n, post_busy, post_en);
        end
        tests_run++;
        if (en_n !== 2 || mem_diffs() !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_mem: writes=%0d diffs=%0d, required 2 0", en_n, mem_diffs());
        end
        $display("[TB] reset mid-copy %h->%h: writes=%0d", s, d, en_n);
    endtask

    task automatic test_busy_start();
        logic [7:0] s, d;
        s = 8'($urandom); d = 8'($urandom);
        model_copy(s, d, 6);
        run_copy(s, d, 9'd6, 3, 0, 16);
        tests_run++;
        if (done_k !== 13 || done_n !== 1 || en_n !== 6 || busy_n !== 12 || mem_diffs() !== 0) begin
            tests_failed++;
            $display("FAIL busy_start: done=%0d pulses=%0d en=%0d busy=%0d diffs=%0d, required 13 1 6 12 0",
                     done_k, done_n, en_n, busy_n, mem_diffs());
        end
        model_copy(d, s, 3);
        run_copy(d, s, 9'd3, 6, 0, 10);
        tests_run++;
        if (done_n !== 1 || busy_n !== 6 || mem_diffs() !== 0) begin
            tests_failed++;
            $display("FAIL done_start: pulses=%0d busy=%0d diffs=%0d, required 1 6 0", done_n, busy_n, mem_diffs());
        end
        $display("[TB] start while busy ignored: done at %0d", done_k);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] s, d;
            int n;
            s = 8'($urandom); d = 8'($urandom);
            n = (it == 0) ? 256 : (it == 1) ? 0 : int'($urandom_range(1, 40));
            model_copy(s, d, n);
            run_copy(s, d, 9'(n), 0, 0, 2 * n + 4);
            tests_run++;
            if (done_k !== 2 * n + 1 || done_n !== 1 || busy_n !== 2 * n || en_n !== n) begin
                tests_failed++;
                $display("FAIL rand_timing: len=%0d done=%0d pulses=%0d busy=%0d en=%0d, required %0d 1 %0d %0d",
                         n, done_k, done_n, busy_n, en_n, 2 * n + 1, 2 * n, n);
            end
            tests_run++;
            if (seq_diffs(s, d, n) !== 0 || mem_diffs() !== 0) begin
                tests_failed++;
                $display("FAIL rand_data: len=%0d %h->%h addr_errs=%0d mem_diffs=%0d, required 0 0",
                         n, s, d, seq_diffs(s, d, n), mem_diffs());
            end
`ifdef DMEM_DMA_CSUM_EN
            tests_run++;
            if (csum_at_done !== model_sum || csum !== model_sum) begin
                tests_failed++;
                $display("FAIL rand_csum: at_done=%h now=%h, required %h", csum_at_done, csum, model_sum);
            end
`endif
            $display("[TB] random copy %h->%h len %0d: done at %0d", s, d, n, done_k);
        end
    endtask

`ifdef DMEM_DMA_CSUM_EN
    task automatic test_csum();
        poke(8'h40, 8'h80); poke(8'h41, 8'h90); poke(8'h42, 8'hF0);
        model_copy(8'h40, 8'hC0, 3);
        run_copy(8'h40, 8'hC0, 9'd3, 0, 0, 10);
        repeat (3) @(negedge clk);
        tests_run++;
        if (csum_at_done !== 8'h00 || csum !== 8'h00) begin
            tests_failed++;
            $display("FAIL csum_wrap: at_done=%h held=%h, required 00 00", csum_at_done, csum);
        end
        $display("[TB] checksum 80+90+F0: %h", csum_at_done);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
        test_reset();
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        test_basic();
        test_zero_len();
        test_wrap();
        test_overlap();
        test_reset_mid();
        test_busy_start();
        test_random();
`ifdef DMEM_DMA_CSUM_EN
        test_csum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/dmem_dma.md
Name: dmem_dma

Overview:
- Data-memory initiator. Copies a block of words from one region of the data RAM to another.
- Drives the RAM control fields (addr, in, en) and samples the RAM's combinational read data.
- Sits beside the core as a second DMemCtrl master. Arbitration between the two is handled outside this block.
- Software programs src/dst/len, pulses start, then waits for done.

Parameters:
- D, 8, data word width; must match the RAM's D.
- A, 8, address width; the RAM holds 2**A words.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch a copy; sampled only in IDLE.
- src  input  A  first source word address.
- dst  input  A  first destination word address.
- len  input  A+1  number of words to copy; 0 to 2**A.
- dmem_addr  output  A  connects to DMemCtrl addr.
- dmem_in  output  D  connects to DMemCtrl in (write data).
- dmem_en  output  1  connects to DMemCtrl en (write enable).
- dmem_out  input  D  RAM combinational read data for dmem_addr.
- busy  output  1  high while a copy is in progress.
- done  output  1  one-cycle pulse when a copy finishes.

Behaviour:
- Reset values: state IDLE; dmem_addr=0, dmem_in=0, dmem_en=0, busy=0, done=0; internal counters and word buffer cleared.
- Clock and reset: one clock; reset is synchronous and active-high.
- start handling:
  - On start in IDLE, latch src, dst and len into internal regs. Later changes on these inputs have no effect on the copy in flight.
  - start while busy=1 is ignored.
- State IDLE: dmem_en=0, busy=0.
  - start with len!=0 -> READ.
  - start with len==0 -> DONE. No RAM write occurs.
- State READ (busy=1):
  - dmem_addr = src_q + idx, dmem_en=0.
  - At the clock edge, capture dmem_out into buf, then -> WRITE.
- State WRITE (busy=1):
  - dmem_addr = dst_q + idx, dmem_in = buf, dmem_en=1 for exactly this cycle.
  - At the edge, idx increments.
  - If idx+1 == len_q -> DONE, else -> READ.
- State DONE: done=1 and busy=0 for one cycle, dmem_en=0, then -> IDLE.
- Timing:
  - Each word takes exactly 2 cycles.
  - A copy of N words occupies N*2 busy cycles plus 1 done cycle.
  - done is asserted 2N+1 cycles after the start edge.
- Address arithmetic is modulo 2**A: src_q+idx and dst_q+idx wrap (0xFF+1 -> 0x00 at A=8).
- idx is A+1 bits wide so len=2**A is legal and terminates correctly.
- Overlapping regions are copied strictly in ascending order, word by word.
  - Consequence: dst in (src, src+len) replicates the leading words. This is specified behaviour, not an error.
- Outputs are registered from state. dmem_addr/dmem_in/dmem_en are stable for the whole cycle, so the RAM write occurs at the edge closing WRITE.
- Reset mid-copy: next edge returns to IDLE with dmem_en=0 and no done pulse. Words already written stay written.
- start and rst asserted on the same edge: rst wins.

Optional Feature:
- Macro: DMEM_DMA_CSUM_EN.
- When defined:
  - Adds an output port csum, width D.
  - csum is cleared on accepted start and on rst.
  - It accumulates buf modulo 2**D on every WRITE cycle.
  - It holds its final value from the DONE cycle until the next start.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Basic copy: RAM[0x10..0x13]=11,22,33,44; src=0x10, dst=0x80, len=4, pulse start.
  - Expect RAM[0x80..0x83]=11,22,33,44.
  - Expect done exactly 9 cycles after start, busy high for 8 cycles, dmem_en high for exactly 4 cycles.
- Zero length: len=0, start.
  - Expect done on the next cycle, dmem_en never asserted, RAM unchanged.
- Wrap-around: src=0xFE, dst=0x01, len=3, RAM[0xFE]=A1, RAM[0xFF]=B2, RAM[0x00]=C3.
  - Expect RAM[0x01..0x03]=A1,B2,C3.
  - Expect dmem_addr sequence FE,01,FF,02,00,03.
- Overlap forward: RAM[0x20]=5A, RAM[0x21]=00; src=0x20, dst=0x21, len=2.
  - Expect RAM[0x21]=5A and RAM[0x22]=5A.
- Reset and re-start interference:
  - Assert rst after the 2nd write of a len=8 copy. Expect only 2 destination words changed, no done pulse, busy=0 and dmem_en=0 after the edge.
  - Pulse start while busy. Expect it to be ignored.
- Checksum (with DMEM_DMA_CSUM_EN): copy 80,90,F0.
  - Expect csum=0x00 (0x200 mod 256) at done, and csum held until the next start.
